// File: rtl/otter_pkg.sv
// Shared OTTER encodings: opcodes, ALU codes, datapath select values and control FSM states.
// Pure constants and one helper; no latency, no backpressure.
package otter_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_LUI  = 4'b1001;
   localparam logic [3:0] ALU_SRA  = 4'b1101;

   localparam logic       SRCA_RS1  = 1'b0;
   localparam logic       SRCA_UIMM = 1'b1;

   localparam logic [1:0] SRCB_RS2  = 2'd0;
   localparam logic [1:0] SRCB_IIMM = 2'd1;
   localparam logic [1:0] SRCB_SIMM = 2'd2;
   localparam logic [1:0] SRCB_PC   = 2'd3;

   localparam logic [2:0] PC_PLUS4  = 3'd0;
   localparam logic [2:0] PC_JALR   = 3'd1;
   localparam logic [2:0] PC_BRANCH = 3'd2;
   localparam logic [2:0] PC_JAL    = 3'd3;
   localparam logic [2:0] PC_MTVEC  = 3'd4;

   localparam logic [1:0] RF_PC4 = 2'd0;
   localparam logic [1:0] RF_MEM = 2'd2;
   localparam logic [1:0] RF_ALU = 2'd3;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_FETCH,
      ST_EXEC,
      ST_WB,
      ST_INTR
   } state_t;

   // Unsupported funct3 values report not-taken; the decoder flags them separately.
   function automatic logic branch_taken(input logic [2:0] funct3, input logic eq,
                                         input logic lt, input logic ltu);
      case (funct3)
         3'b000:  return eq;
         3'b001:  return !eq;
         3'b100:  return lt;
         3'b101:  return !lt;
         3'b110:  return ltu;
         3'b111:  return !ltu;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/otter_ctrl_unit_if.sv
// Control bundle from the control unit (master) to datapath, register file and memory (slave).
// Wires only; no latency, no backpressure.
interface otter_ctrl_unit_if;
   import otter_pkg::*;

   logic [3:0] alu_fun;
   logic       alu_srcA;
   logic [1:0] alu_srcB;
   logic [2:0] pc_source;
   logic [1:0] rf_wr_sel;
   logic       pc_write;
   logic       reg_write;
   logic       mem_we2;
   logic       mem_rden1;
   logic       mem_rden2;
   logic       rst_pc;
   logic       int_taken;
   logic       illegal;

   modport master (
      output alu_fun, alu_srcA, alu_srcB, pc_source, rf_wr_sel, pc_write, reg_write,
             mem_we2, mem_rden1, mem_rden2, rst_pc, int_taken, illegal
   );

   modport slave (
      input alu_fun, alu_srcA, alu_srcB, pc_source, rf_wr_sel, pc_write, reg_write,
            mem_we2, mem_rden1, mem_rden2, rst_pc, int_taken, illegal
   );

endinterface

// File: rtl/otter_dcdr.sv
// Combinational instruction decoder: opcode/funct3/branch flags to selects and alu_fun.
// Zero latency, no backpressure; strobes and illegal are qualified by exec.
module otter_dcdr
   import otter_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       ir30,
   input  logic       br_eq,
   input  logic       br_lt,
   input  logic       br_ltu,
   input  logic       exec,
   output logic [3:0] alu_fun,
   output logic       alu_srcA,
   output logic [1:0] alu_srcB,
   output logic [2:0] pc_source,
   output logic [1:0] rf_wr_sel,
   output logic       reg_write,
   output logic       mem_we2,
   output logic       mem_rden2,
   output logic       illegal,
   output logic       is_load
);

   logic wr, we, rd, bad;

   always_comb begin
      alu_fun   = ALU_ADD;
      alu_srcA  = SRCA_RS1;
      alu_srcB  = SRCB_RS2;
      pc_source = PC_PLUS4;
      rf_wr_sel = RF_PC4;
      is_load   = 1'b0;
      wr        = 1'b0;
      we        = 1'b0;
      rd        = 1'b0;
      bad       = 1'b0;

      case (opcode)
         OPC_OP: begin
            alu_fun   = {ir30, funct3};
            rf_wr_sel = RF_ALU;
            wr        = 1'b1;
         end
         OPC_OP_IMM: begin
            // Only the shift-right immediate uses ir[30]; elsewhere it is immediate data.
            alu_fun   = {(funct3 == 3'b101) ? ir30 : 1'b0, funct3};
            alu_srcB  = SRCB_IIMM;
            rf_wr_sel = RF_ALU;
            wr        = 1'b1;
         end
         OPC_LUI: begin
            alu_fun   = ALU_LUI;
            alu_srcA  = SRCA_UIMM;
            rf_wr_sel = RF_ALU;
            wr        = 1'b1;
         end
         OPC_AUIPC: begin
            alu_srcA  = SRCA_UIMM;
            alu_srcB  = SRCB_PC;
            rf_wr_sel = RF_ALU;
            wr        = 1'b1;
         end
         OPC_JAL: begin
            pc_source = PC_JAL;
            wr        = 1'b1;
         end
         OPC_JALR: begin
            pc_source = PC_JALR;
            wr        = 1'b1;
         end
         OPC_LOAD: begin
            alu_srcB = SRCB_IIMM;
            rd       = 1'b1;
            is_load  = 1'b1;
         end
         OPC_STORE: begin
            alu_srcB = SRCB_SIMM;
            we       = 1'b1;
         end
         OPC_BRANCH: begin
            if (funct3 == 3'b010 || funct3 == 3'b011)
               bad = 1'b1;
            else if (branch_taken(funct3, br_eq, br_lt, br_ltu))
               pc_source = PC_BRANCH;
         end
         default: bad = 1'b1;
      endcase

      reg_write = wr & exec;
      mem_we2   = we & exec;
      mem_rden2 = rd & exec;
      illegal   = bad & exec;
   end

endmodule

// File: rtl/otter_ctrl_unit.sv
// Multi-cycle OTTER control FSM (INIT/FETCH/EXEC/WB/INTR) driving the datapath control bundle.
// One cycle per state, loads add WB, interrupts add INTR; no backpressure.
module otter_ctrl_unit
   import otter_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [31:0]               ir,
   input  logic                      br_eq,
   input  logic                      br_lt,
   input  logic                      br_ltu,
   input  logic                      intr,
   input  logic                      int_en,
   otter_ctrl_unit_if.master         ctrl
);

   state_t     state, state_nxt;
   logic [3:0] d_alu_fun;
   logic       d_srcA;
   logic [1:0] d_srcB;
   logic [2:0] d_pc_source;
   logic [1:0] d_rf_wr_sel;
   logic       d_reg_write, d_mem_we2, d_mem_rden2, d_illegal, d_is_load;
   logic       irq;
   logic       unused_ir;

   assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};
   assign irq       = intr & int_en;

   otter_dcdr u_dcdr (
      .opcode    (ir[6:0]),
      .funct3    (ir[14:12]),
      .ir30      (ir[30]),
      .br_eq     (br_eq),
      .br_lt     (br_lt),
      .br_ltu    (br_ltu),
      .exec      (state == ST_EXEC),
      .alu_fun   (d_alu_fun),
      .alu_srcA  (d_srcA),
      .alu_srcB  (d_srcB),
      .pc_source (d_pc_source),
      .rf_wr_sel (d_rf_wr_sel),
      .reg_write (d_reg_write),
      .mem_we2   (d_mem_we2),
      .mem_rden2 (d_mem_rden2),
      .illegal   (d_illegal),
      .is_load   (d_is_load)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_INIT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      ctrl.alu_fun   = ALU_ADD;
      ctrl.alu_srcA  = SRCA_RS1;
      ctrl.alu_srcB  = SRCB_RS2;
      ctrl.pc_source = PC_PLUS4;
      ctrl.rf_wr_sel = RF_PC4;
      ctrl.pc_write  = 1'b0;
      ctrl.reg_write = 1'b0;
      ctrl.mem_we2   = 1'b0;
      ctrl.mem_rden1 = 1'b0;
      ctrl.mem_rden2 = 1'b0;
      ctrl.rst_pc    = 1'b0;
      ctrl.int_taken = 1'b0;
      ctrl.illegal   = 1'b0;

      case (state)
         ST_INIT: begin
            ctrl.rst_pc = 1'b1;
            state_nxt   = ST_FETCH;
         end
         ST_FETCH: begin
            ctrl.mem_rden1 = 1'b1;
            state_nxt      = ST_EXEC;
         end
         ST_EXEC: begin
            ctrl.alu_fun   = d_alu_fun;
            ctrl.alu_srcA  = d_srcA;
            ctrl.alu_srcB  = d_srcB;
            ctrl.pc_source = d_pc_source;
            ctrl.rf_wr_sel = d_rf_wr_sel;
            ctrl.reg_write = d_reg_write;
            ctrl.mem_we2   = d_mem_we2;
            ctrl.mem_rden2 = d_mem_rden2;
            ctrl.illegal   = d_illegal;
            ctrl.pc_write  = !d_is_load;
            if (d_is_load) state_nxt = ST_WB;
            else           state_nxt = irq ? ST_INTR : ST_FETCH;
         end
         ST_WB: begin
            // ir is stable, so the decoder still supplies the load's address selects.
            ctrl.alu_fun   = d_alu_fun;
            ctrl.alu_srcB  = d_srcB;
            ctrl.mem_rden2 = 1'b1;
            ctrl.rf_wr_sel = RF_MEM;
            ctrl.reg_write = !rst;
            ctrl.pc_write  = 1'b1;
            state_nxt      = irq ? ST_INTR : ST_FETCH;
         end
         ST_INTR: begin
            ctrl.pc_source = PC_MTVEC;
            ctrl.pc_write  = 1'b1;
            ctrl.int_taken = 1'b1;
            state_nxt      = ST_FETCH;
         end
         default: state_nxt = ST_INIT;
      endcase
   end

endmodule

// File: tb/tb_otter_ctrl_unit.sv
// Bench for otter_ctrl_unit: directed steps then random instructions vs an instruction-level model.
module tb_otter_ctrl_unit;

   typedef struct packed {
      logic [3:0] alu_fun;
      logic       alu_srcA;
      logic [1:0] alu_srcB;
      logic [2:0] pc_source;
      logic [1:0] rf_wr_sel;
      logic       pc_write;
      logic       reg_write;
      logic       mem_we2;
      logic       mem_rden1;
      logic       mem_rden2;
      logic       rst_pc;
      logic       int_taken;
      logic       illegal;
   } outs_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] ir = 32'h0;
   logic        br_eq = 1'b0, br_lt = 1'b0, br_ltu = 1'b0;
   logic        intr = 1'b0, int_en = 1'b0;

   int total = 0;
   int bad   = 0;
   outs_t last_exec, last_intr;

   otter_ctrl_unit_if ctrl ();

   otter_ctrl_unit dut (
      .clk    (clk),
      .rst    (rst),
      .ir     (ir),
      .br_eq  (br_eq),
      .br_lt  (br_lt),
      .br_ltu (br_ltu),
      .intr   (intr),
      .int_en (int_en),
      .ctrl   (ctrl)
   );

   always #5 clk = ~clk;

   function automatic outs_t get_obs();
      outs_t o;
      o.alu_fun   = ctrl.alu_fun;
      o.alu_srcA  = ctrl.alu_srcA;
      o.alu_srcB  = ctrl.alu_srcB;
      o.pc_source = ctrl.pc_source;
      o.rf_wr_sel = ctrl.rf_wr_sel;
      o.pc_write  = ctrl.pc_write;
      o.reg_write = ctrl.reg_write;
      o.mem_we2   = ctrl.mem_we2;
      o.mem_rden1 = ctrl.mem_rden1;
      o.mem_rden2 = ctrl.mem_rden2;
      o.rst_pc    = ctrl.rst_pc;
      o.int_taken = ctrl.int_taken;
      o.illegal   = ctrl.illegal;
      return o;
   endfunction

   function automatic outs_t init_exp();
      outs_t o = '0;
      o.rst_pc = 1'b1;
      return o;
   endfunction

   function automatic outs_t fetch_exp();
      outs_t o = '0;
      o.mem_rden1 = 1'b1;
      return o;
   endfunction

   function automatic outs_t wb_exp();
      outs_t o = '0;
      o.alu_srcB  = 2'd1;
      o.mem_rden2 = 1'b1;
      o.rf_wr_sel = 2'd2;
      o.reg_write = 1'b1;
      o.pc_write  = 1'b1;
      return o;
   endfunction

   function automatic outs_t intr_exp();
      outs_t o = '0;
      o.pc_source = 3'd4;
      o.pc_write  = 1'b1;
      o.int_taken = 1'b1;
      return o;
   endfunction

   // Instruction-level semantics: which ALU operation each mnemonic needs.
   function automatic logic [3:0] alu_for(input logic [2:0] f3, input logic alt, input logic imm);
      case (f3)
         3'd0: return (alt && !imm) ? 4'b1000 : 4'b0000;
         3'd1: return 4'b0001;
         3'd2: return 4'b0010;
         3'd3: return 4'b0011;
         3'd4: return 4'b0100;
         3'd5: return alt ? 4'b1101 : 4'b0101;
         3'd6: return 4'b0110;
         default: return 4'b0111;
      endcase
   endfunction

   function automatic outs_t exec_exp(input logic [31:0] i, input logic eq, input logic lt,
                                      input logic ltu);
      outs_t o = '0;
      logic [2:0] f3 = i[14:12];
      logic taken;
      o.pc_write = 1'b1;
      case (i[6:0])
         7'h33: begin o.alu_fun = alu_for(f3, i[30], 1'b0); o.rf_wr_sel = 2'd3; o.reg_write = 1'b1; end
         7'h13: begin o.alu_fun = alu_for(f3, i[30], 1'b1); o.alu_srcB = 2'd1;
                      o.rf_wr_sel = 2'd3; o.reg_write = 1'b1; end
         7'h37: begin o.alu_fun = 4'b1001; o.alu_srcA = 1'b1; o.rf_wr_sel = 2'd3; o.reg_write = 1'b1; end
         7'h17: begin o.alu_srcA = 1'b1; o.alu_srcB = 2'd3; o.rf_wr_sel = 2'd3; o.reg_write = 1'b1; end
         7'h6F: begin o.pc_source = 3'd3; o.reg_write = 1'b1; end
         7'h67: begin o.pc_source = 3'd1; o.reg_write = 1'b1; end
         7'h03: begin o.alu_srcB = 2'd1; o.mem_rden2 = 1'b1; o.pc_write = 1'b0; end
         7'h23: begin o.alu_srcB = 2'd2; o.mem_we2 = 1'b1; end
         7'h63: begin
            taken = 1'b0;
            if (f3 == 3'd0) taken = eq;
            if (f3 == 3'd1) taken = !eq;
            if (f3 == 3'd4) taken = lt;
            if (f3 == 3'd5) taken = !lt;
            if (f3 == 3'd6) taken = ltu;
            if (f3 == 3'd7) taken = !ltu;
            if (f3 == 3'd2 || f3 == 3'd3) o.illegal = 1'b1;
            o.pc_source = taken ? 3'd2 : 3'd0;
         end
         default: o.illegal = 1'b1;
      endcase
      return o;
   endfunction

   task automatic check(input string tag, input outs_t exp);
      outs_t obs;
      obs = get_obs();
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_nib(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   // Entered just after the edge into FETCH; returns just after the edge into the next FETCH.
   task automatic run_instr(input logic [31:0] i, input logic eq, input logic lt, input logic ltu,
                            input logic irq, input logic en, input string tag);
      ir = i; br_eq = eq; br_lt = lt; br_ltu = ltu; intr = irq; int_en = en;
      #1 check({tag, ":fetch"}, fetch_exp());
      next_cycle();
      #1 check({tag, ":exec"}, exec_exp(i, eq, lt, ltu));
      last_exec = get_obs();
      if (i[6:0] == 7'h03) begin
         next_cycle();
         #1 check({tag, ":wb"}, wb_exp());
      end
      if (irq && en) begin
         next_cycle();
         #1 check({tag, ":intr"}, intr_exp());
         last_intr = get_obs();
      end
      next_cycle();
   endtask

   initial begin
      outs_t e;
      logic [31:0] ri;
      logic [6:0]  ops [9];
      ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63};

      // Reset and first fetch
      rst = 1'b1;
      next_cycle();
      check("reset_held", init_exp());
      rst = 1'b0;
      #1 check("init", init_exp());
      next_cycle();

      run_instr(32'h002081B3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "add");
      check_nib("add_alu_fun", last_exec.alu_fun, 4'b0000);
      check_bit("add_reg_write", last_exec.reg_write, 1'b1);
      run_instr(32'h402081B3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "sub");
      check_nib("sub_alu_fun", last_exec.alu_fun, 4'b1000);
      run_instr(32'h4030D293, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "srai");
      check_nib("srai_alu_fun", last_exec.alu_fun, 4'b1101);
      run_instr(32'h123452B7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "lui");
      check_nib("lui_alu_fun", last_exec.alu_fun, 4'b1001);
      check_bit("lui_srcA", last_exec.alu_srcA, 1'b1);
      run_instr(32'h0000A283, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "lw");
      check_bit("lw_exec_pc_write", last_exec.pc_write, 1'b0);
      run_instr(32'h00208463, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "beq_taken");
      check_nib("beq_taken_pcsrc", {1'b0, last_exec.pc_source}, 4'd2);
      run_instr(32'h00208463, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "beq_not_taken");
      check_nib("beq_nt_pcsrc", {1'b0, last_exec.pc_source}, 4'd0);
      run_instr(32'h0020A463, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "branch_f3_010");
      check_bit("branch_illegal", last_exec.illegal, 1'b1);
      run_instr(32'h002081B3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "add_irq");
      check_bit("add_irq_reg_write", last_exec.reg_write, 1'b1);
      check_bit("add_irq_int_taken", last_intr.int_taken, 1'b1);
      run_instr(32'h002081B3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "add_irq_masked");

      // Reset during WB abandons the load
      ir = 32'h0000A283; intr = 1'b0; int_en = 1'b0;
      #1 check("lw_rst:fetch", fetch_exp());
      next_cycle();
      #1 check("lw_rst:exec", exec_exp(ir, 1'b0, 1'b0, 1'b0));
      next_cycle();
      rst = 1'b1;
      e = wb_exp();
      e.reg_write = 1'b0;
      #1 check("lw_rst:wb", e);
      next_cycle();
      rst = 1'b0;
      #1 check("lw_rst:init", init_exp());
      next_cycle();

      // Interrupt seen only during a load's EXEC is ignored
      ir = 32'h0000A283; intr = 1'b1; int_en = 1'b1;
      #1 check("lw_irq_exec:fetch", fetch_exp());
      next_cycle();
      #1 check("lw_irq_exec:exec", exec_exp(ir, 1'b0, 1'b0, 1'b0));
      intr = 1'b0;
      next_cycle();
      #1 check("lw_irq_exec:wb", wb_exp());
      next_cycle();
      #1 check("lw_irq_exec:no_intr", fetch_exp());
      #1;

      // Random instruction stream
      for (int n = 0; n < 300; n++) begin
         ri = $urandom;
         if ($urandom_range(0, 9) == 0) ri[6:0] = 7'($urandom);
         else ri[6:0] = ops[$urandom_range(0, 8)];
         if (ri[6:0] == 7'h33)
            ri[31:25] = (ri[14:12] == 3'd0 || ri[14:12] == 3'd5) ? {1'b0, ri[30], 5'd0} : 7'd0;
         run_instr(ri, 1'($urandom), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0), 1'($urandom), $sformatf("rand%0d_%h", n, ri));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/otter_ctrl_unit.md
Name: otter_ctrl_unit

Overview:
- Multi-cycle control unit for the OTTER RV32I core.
- Sequences fetch/execute/writeback and decodes the instruction register into datapath selects and write strobes.
- Produces the 4-bit `alu_fun` code the ALU consumes. It is the driving end of the ALU function interface.
- Sits between instruction memory output (`ir`), the branch comparator, the interrupt input, and the datapath muxes, register file and memory.

Parameters:
- None. Encodings are fixed constants from the shared package.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ir  in  32  current instruction word, valid from the EXEC state onward
- br_eq  in  1  rs1 == rs2
- br_lt  in  1  signed rs1 < rs2
- br_ltu  in  1  unsigned rs1 < rs2
- intr  in  1  external interrupt request, level
- int_en  in  1  interrupt enable (mie)
- alu_fun  out  4  ALU operation code
- alu_srcA  out  1  0=rs1, 1=U-immediate
- alu_srcB  out  2  0=rs2, 1=I-imm, 2=S-imm, 3=pc
- pc_source  out  3  0=pc+4, 1=jalr, 2=branch, 3=jal, 4=mtvec
- rf_wr_sel  out  2  0=pc+4, 2=mem, 3=alu_out
- pc_write  out  1  PC load strobe
- reg_write  out  1  register file write strobe
- mem_we2  out  1  data memory write
- mem_rden1  out  1  instruction read
- mem_rden2  out  1  data read
- rst_pc  out  1  clear PC
- int_taken  out  1  interrupt entry pulse
- illegal  out  1  unsupported opcode or branch funct3 in EXEC

Behaviour:
- States: ST_INIT, ST_FETCH, ST_EXEC, ST_WB, ST_INTR. Encoded state is registered; outputs are combinational from state and `ir`.
- Reset (sync): `rst` high at an edge puts the FSM in ST_INIT regardless of current state.
  - A reset arriving while in ST_WB abandons the load: no `reg_write`.
  - In ST_INIT: `rst_pc`=1; all strobes 0; `alu_fun`=0000; all selects 0. Next state is always ST_FETCH.
- ST_FETCH: `mem_rden1`=1, all other strobes 0. Next state is ST_EXEC. Latency from FETCH entry to EXEC is 1 cycle.
- ST_EXEC, by opcode:
  - OP (0110011): `alu_fun`={ir[30],funct3}; srcA=0; srcB=0; `rf_wr_sel`=3; `reg_write`=1.
  - OP-IMM (0010011): `alu_fun`={funct3==101 ? ir[30] : 0, funct3}; srcB=1; `rf_wr_sel`=3; `reg_write`=1.
  - LUI (0110111): `alu_fun`=1001; srcA=1; `rf_wr_sel`=3; `reg_write`=1.
  - AUIPC (0010111): `alu_fun`=0000; srcA=1; srcB=3; `rf_wr_sel`=3; `reg_write`=1.
  - JAL (1101111): `pc_source`=3; `rf_wr_sel`=0; `reg_write`=1.
  - JALR (1100111): `pc_source`=1; `rf_wr_sel`=0; `reg_write`=1.
  - LOAD (0000011): `alu_fun`=0000; srcB=1; `mem_rden2`=1; no `pc_write`; next state ST_WB.
  - STORE (0100011): `alu_fun`=0000; srcB=2; `mem_we2`=1.
  - BRANCH (1100011): `pc_source`=2 if taken, else 0. Taken conditions by funct3: 000 eq; 001 !eq; 100 lt; 101 !lt; 110 ltu; 111 !ltu. funct3 010/011: `illegal`=1, `pc_source`=0.
  - Any other opcode: `illegal`=1, treated as a NOP (`pc_write` only).
  - `pc_write`=1 for every non-LOAD opcode.
- ST_WB: `alu_fun`, srcB and `mem_rden2` are held from EXEC; `rf_wr_sel`=2; `reg_write`=1; `pc_write`=1.
- Interrupts:
  - Leaving EXEC (non-LOAD) or WB, if `intr`&&`int_en` is sampled at the edge, the next state is ST_INTR; otherwise ST_FETCH.
  - The current instruction always completes first: its strobes fire in the same cycle.
  - ST_INTR: `pc_source`=4; `pc_write`=1; `int_taken`=1 for exactly one cycle; next state ST_FETCH.
  - `intr` is ignored in INIT, FETCH, INTR, and in EXEC of a LOAD.

Decomposition:
- Shared package `otter_pkg` holds:
  - Opcode constants.
  - ALU function codes: ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, LUI 1001, SRA 1101.
  - srcA/srcB/pc_source/rf_wr_sel encodings.
  - FSM state typedef.
- One sub-module, `otter_dcdr`: the combinational decoder from `ir`, `br_*` and an exec flag to selects and `alu_fun`. The FSM lives in the top module.

Test Plan:
- Reset and fetch: hold `rst` 1 cycle, then release → `rst_pc`=1 in ST_INIT; next cycle `mem_rden1`=1; no write strobes in either cycle.
- R-type decode:
  - `ir`=0x002081B3 (add) in EXEC → `alu_fun`=0000, `reg_write`=1, `rf_wr_sel`=3, `pc_write`=1.
  - `ir`=0x402081B3 (sub) → `alu_fun`=1000.
- Shift and LUI decode:
  - `ir`=0x4030D293 (srai) → `alu_fun`=1101, srcB=1.
  - `ir`=0x123452B7 (lui) → `alu_fun`=1001, srcA=1.
- Load sequencing: `ir`=0x0000A283 (lw) → EXEC `mem_rden2`=1, `pc_write`=0; WB `reg_write`=1, `rf_wr_sel`=2, `pc_write`=1. Asserting `rst` during WB → next cycle ST_INIT, no `reg_write`.
- Branch: `ir`=0x00208463 (beq):
  - `br_eq`=1 → `pc_source`=2.
  - `br_eq`=0 → `pc_source`=0.
  - funct3 forced to 010 → `illegal`=1.
- Interrupt: `intr`=1, `int_en`=1 during EXEC of add → add's `reg_write` fires; next cycle `int_taken`=1, `pc_source`=4; then FETCH. Same stimulus with `int_en`=0 → no INTR state.
